// File: rtl/i2s_audio_rx.sv
// I2S receiver: oversamples BCLK/LRCK/SDATA in the system clock, deserializes
// stereo samples, and reports audio activity, framing errors and loss of lock.
module i2s_audio_rx #(
    parameter int SAMPLE_WIDTH    = 24,
    parameter int SLOT_WIDTH      = 32,
    parameter int ACTIVITY_THRESH = 4096,
    parameter int SILENCE_SAMPLES = 96000,
    parameter int BCLK_TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i2s_bclk,
    input  logic                    i2s_lrck,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] l_audio_data,
    output logic [SAMPLE_WIDTH-1:0] r_audio_data,
    output logic [7:0]              l_audio_signal,
    output logic [7:0]              r_audio_signal,
    output logic                    l_data_en,
    output logic                    r_data_en,
    output logic                    audio_enable,
    output logic                    frame_error
);

    localparam int TW = $clog2(BCLK_TIMEOUT + 1);
    localparam int QW = $clog2(SILENCE_SAMPLES + 1);
    localparam logic [TW-1:0]           TIMEOUT    = TW'(BCLK_TIMEOUT);
    localparam logic [QW-1:0]           SILENCE    = QW'(SILENCE_SAMPLES);
    localparam logic [QW-1:0]           SILENCE_M1 = QW'(SILENCE_SAMPLES - 1);
    localparam logic [SAMPLE_WIDTH-1:0] THRESH     = SAMPLE_WIDTH'(ACTIVITY_THRESH);

    typedef enum logic {ACQUIRE, RUN} state_t;

    state_t                  state, state_next;
    logic [1:0]              bclk_sync, lrck_sync, sdata_sync;
    logic                    bclk_prev;
    logic                    bclk_rise, lrck_s, sdata_s;
    logic                    lrck_prev, channel;
    logic [5:0]              bit_cnt, bit_cnt_next;
    logic [SAMPLE_WIDTH-2:0] shreg;
    logic [TW-1:0]           to_cnt;
    logic [QW-1:0]           quiet_cnt;
    logic                    lock_lost, acquire_hit, run_rise, boundary;
    logic                    shift_en, sample_done, slot_bad, loud;
    logic [SAMPLE_WIDTH-1:0] sample_word, mag;

    assign bclk_rise = bclk_sync[1] & ~bclk_prev;
    assign lrck_s    = lrck_sync[1];
    assign sdata_s   = sdata_sync[1];
    assign lock_lost = (to_cnt == TIMEOUT);

    assign l_audio_signal = l_audio_data[SAMPLE_WIDTH-1 -: 8];
    assign r_audio_signal = r_audio_data[SAMPLE_WIDTH-1 -: 8];

    // Two-flop synchronizers for the asynchronous I2S pins plus BCLK edge history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync  <= '0;
            lrck_sync  <= '0;
            sdata_sync <= '0;
            bclk_prev  <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[0], i2s_bclk};
            lrck_sync  <= {lrck_sync[0], i2s_lrck};
            sdata_sync <= {sdata_sync[0], i2s_sdata};
            bclk_prev  <= bclk_sync[1];
        end
    end

    // Next-state and per-bit decode; loss of lock overrides everything else
    always_comb begin
        state_next   = state;
        acquire_hit  = 1'b0;
        run_rise     = 1'b0;
        boundary     = 1'b0;
        bit_cnt_next = bit_cnt;
        shift_en     = 1'b0;
        sample_done  = 1'b0;
        slot_bad     = 1'b0;
        sample_word  = {shreg, sdata_s};
        if (lock_lost) begin
            state_next = ACQUIRE;
        end else if (bclk_rise) begin
            case (state)
                ACQUIRE: begin
                    if (lrck_prev && !lrck_s) begin
                        acquire_hit = 1'b1;
                        state_next  = RUN;
                    end
                end
                RUN: begin
                    run_rise = 1'b1;
                    boundary = (lrck_s != lrck_prev);
                    if (boundary) begin
                        bit_cnt_next = '0;
                        slot_bad     = ({1'b0, bit_cnt} + 7'd1) != 7'(SLOT_WIDTH);
                    end else if (bit_cnt != 6'd63) begin
                        bit_cnt_next = bit_cnt + 6'd1;
                    end
                    shift_en    = (bit_cnt_next != '0) && (bit_cnt_next <= 6'(SAMPLE_WIDTH));
                    sample_done = shift_en && (bit_cnt_next == 6'(SAMPLE_WIDTH));
                end
                default: state_next = ACQUIRE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACQUIRE;
        else       state <= state_next;
    end

    // BCLK watchdog: clears on every rise, parks at the timeout value
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          to_cnt <= '0;
        else if (bclk_rise) to_cnt <= '0;
        else if (!lock_lost) to_cnt <= to_cnt + 1'b1;
    end

    // Slot tracking: previous LRCK, bit position, channel and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lrck_prev <= 1'b0;
            bit_cnt   <= '0;
            channel   <= 1'b0;
            shreg     <= '0;
        end else begin
            if (bclk_rise) lrck_prev <= lrck_s;
            if (acquire_hit) begin
                bit_cnt <= '0;
                channel <= 1'b0;
            end else if (run_rise) begin
                bit_cnt <= bit_cnt_next;
                if (boundary) channel <= lrck_s;
                if (shift_en) shreg <= {shreg[SAMPLE_WIDTH-3:0], sdata_s};
            end
        end
    end

    // Sample latch with single-cycle strobes and framing error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_audio_data <= '0;
            r_audio_data <= '0;
            l_data_en    <= 1'b0;
            r_data_en    <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            l_data_en   <= sample_done && !channel;
            r_data_en   <= sample_done && channel;
            frame_error <= slot_bad;
            if (sample_done && !channel) l_audio_data <= sample_word;
            if (sample_done && channel)  r_audio_data <= sample_word;
        end
    end

    // Magnitude of the incoming sample; the most negative code maps to itself
    always_comb begin
        mag  = sample_word[SAMPLE_WIDTH-1] ? (~sample_word + SAMPLE_WIDTH'(1)) : sample_word;
        loud = (mag > THRESH);
    end

    // Activity detector: loud samples arm, a run of quiet left samples disarms
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            audio_enable <= 1'b0;
            quiet_cnt    <= '0;
        end else if (lock_lost) begin
            audio_enable <= 1'b0;
            quiet_cnt    <= '0;
        end else if (sample_done) begin
            if (loud) begin
                audio_enable <= 1'b1;
                quiet_cnt    <= '0;
            end else if (!channel) begin
                if (quiet_cnt != SILENCE)   quiet_cnt    <= quiet_cnt + 1'b1;
                if (quiet_cnt >= SILENCE_M1) audio_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Scoreboard bench for i2s_audio_rx: stimulus pushes expected words, a monitor
// pops and compares on every data strobe.
module tb_i2s_audio_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        i2s_bclk, i2s_lrck, i2s_sdata;
    logic [23:0] l_audio_data, r_audio_data;
    logic [7:0]  l_audio_signal, r_audio_signal;
    logic        l_data_en, r_data_en, audio_enable, frame_error;

    typedef struct {
        logic        ch;
        logic [23:0] data;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   err_pulses = 0;
    bit   jit = 1'b0;

    always #10 clk = ~clk;

    i2s_audio_rx #(
        .SAMPLE_WIDTH   (24),
        .SLOT_WIDTH     (32),
        .ACTIVITY_THRESH(4096),
        .SILENCE_SAMPLES(6),
        .BCLK_TIMEOUT   (255)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrck      (i2s_lrck),
        .i2s_sdata     (i2s_sdata),
        .l_audio_data  (l_audio_data),
        .r_audio_data  (r_audio_data),
        .l_audio_signal(l_audio_signal),
        .r_audio_signal(r_audio_signal),
        .l_data_en     (l_data_en),
        .r_data_en     (r_data_en),
        .audio_enable  (audio_enable),
        .frame_error   (frame_error)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: count error pulses and score every strobe against the queue
    always @(negedge clk) begin
        exp_t e;
        if (frame_error === 1'b1) err_pulses++;
        if (l_data_en === 1'b1 || r_data_en === 1'b1) begin
            check("strobe_overlap", 64'(l_data_en & r_data_en), 64'd0);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got l=%0b r=%0b expected none", l_data_en, r_data_en);
            end else begin
                e = q.pop_front();
                check("channel", 64'(r_data_en), 64'(e.ch));
                check("data", 64'(e.ch ? r_audio_data : l_audio_data), 64'(e.data));
                check("msb_tap", 64'(e.ch ? r_audio_signal : l_audio_signal), 64'(e.data[23:16]));
            end
        end
    end

    task automatic half_wait();
        int n;
        n = jit ? int'($urandom_range(4, 2)) : 3;
        repeat (n) @(negedge clk);
    endtask

    // Transmitter changes LRCK/SDATA on the BCLK falling edge
    task automatic send_bit(input logic lr, input logic d);
        i2s_bclk  = 1'b0;
        i2s_lrck  = lr;
        i2s_sdata = d;
        half_wait();
        i2s_bclk = 1'b1;
        half_wait();
    endtask

    task automatic send_slot(input logic lr, input logic [23:0] w, input int first, input int last);
        for (int i = first; i <= last; i++)
            send_bit(lr, (i >= 1 && i <= 24) ? w[24-i] : 1'b0);
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                              input int lb = 32, input int rb = 32);
        exp_t e;
        if (lb >= 25) begin e.ch = 1'b0; e.data = l; q.push_back(e); end
        if (rb >= 25) begin e.ch = 1'b1; e.data = r; q.push_back(e); end
        send_slot(1'b0, l, 0, lb - 1);
        send_slot(1'b1, r, 0, rb - 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] quiet_l [6];
        logic [23:0] lw, rw;
        quiet_l = '{24'h000100, 24'h001000, 24'hFFF000, 24'h000000, 24'hFFFFFF, 24'h000100};

        reset = 1'b1; i2s_bclk = 1'b0; i2s_lrck = 1'b0; i2s_sdata = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {12'd0, l_audio_data, r_audio_data, l_data_en, r_data_en,
                                audio_enable, frame_error}, 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Lead-in right slot while acquiring: no strobes expected
        send_slot(1'b1, 24'h0, 0, 31);

        // Full-scale extremes and a generic pattern
        send_frame(24'h7FFFFF, 24'h800000);
        check("l_signal_7f", 64'(l_audio_signal), 64'h7F);
        check("r_signal_80", 64'(r_audio_signal), 64'h80);
        check("enable_loud", 64'(audio_enable), 64'd1);
        send_frame(24'h123456, 24'hFEDCBA);
        check("l_data_pattern", 64'(l_audio_data), 64'h123456);

        // Framing: 31-bit right slot, then a 20-bit (short) left slot
        send_frame(24'h0A0B0C, 24'h0D0E0F, 32, 31);
        send_frame(24'h111111, 24'h222222);
        check("err_after_31", 64'(err_pulses), 64'd1);
        send_frame(24'h333333, 24'h444444, 20, 32);
        check("err_after_short", 64'(err_pulses), 64'd2);
        check("short_slot_hold", 64'(l_audio_data), 64'h111111);
        send_frame(24'h555555, 24'h666666);
        check("err_clean_frame", 64'(err_pulses), 64'd2);

        // Silence detection around the threshold
        send_frame(24'h400000, 24'h000100);
        check("enable_before_quiet", 64'(audio_enable), 64'd1);
        for (int k = 0; k < 6; k++) begin
            send_frame(quiet_l[k], 24'hFFF000);
            check($sformatf("quiet_%0d", k + 1), 64'(audio_enable), (k < 5) ? 64'd1 : 64'd0);
        end
        send_frame(24'h001001, 24'h000000);
        check("enable_4097", 64'(audio_enable), 64'd1);
        for (int k = 0; k < 6; k++) send_frame(24'h000000, 24'h000000);
        check("enable_dropped", 64'(audio_enable), 64'd0);
        send_frame(24'h000000, 24'hFFEFFF);
        check("enable_right_loud", 64'(audio_enable), 64'd1);

        // BCLK stall: lock held before the timeout, lost after it
        repeat (200) @(negedge clk);
        check("no_early_timeout", 64'(audio_enable), 64'd1);
        repeat (100) @(negedge clk);
        check("timeout_enable", 64'(audio_enable), 64'd0);
        check("timeout_hold", 64'(r_audio_data), 64'hFFEFFF);
        send_slot(1'b1, 24'h0, 10, 31);
        send_frame(24'h7A0000, 24'h0B0000);
        check("relock_enable", 64'(audio_enable), 64'd1);

        // Reset in the middle of a left slot
        send_slot(1'b0, 24'h765432, 0, 9);
        reset = 1'b1;
        #1;
        check("midreset_outputs", {12'd0, l_audio_data, r_audio_data, l_data_en, r_data_en,
                                   audio_enable, frame_error}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        send_slot(1'b0, 24'h765432, 10, 31);
        send_slot(1'b1, 24'h89ABCD, 0, 31);
        send_frame(24'h010203, 24'hF0E0D0);
        check("post_reset_left", 64'(l_audio_data), 64'h010203);

        // Jittered BCLK with arbitrary words
        jit = 1'b1;
        for (int f = 0; f < 30; f++) begin
            lw = 24'($urandom);
            rw = 24'($urandom);
            send_frame(lw, rw);
        end
        jit = 1'b0;
        send_slot(1'b0, 24'h0, 0, 3);
        check("err_total", 64'(err_pulses), 64'd2);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
